// File: rtl/response_checker_if.sv
// Handshake and result bundle between a bench (or on-chip harness) and response_checker.
// The master drives the run control, the stimulus and the cell output. The slave returns status and counts.
interface response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [1:0]       func_sel;
    logic             a;
    logic             b;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             first_fail_valid;
    logic [CNT_W-1:0] first_fail_idx;

    modport master (
        output start, stop, func_sel, a, b, y,
        input  busy, done, pass, vec_cnt, err_cnt, first_fail_valid, first_fail_idx
    );

    modport slave (
        input  start, stop, func_sel, a, b, y,
        output busy, done, pass, vec_cnt, err_cnt, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/response_checker.sv
// Checks a registered two-input logic cell against a golden function that is delayed by LATENCY cycles.
// It counts vectors and errors, records the index of the first failing vector and reports a pass/fail verdict.
module response_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    response_checker_if.slave  rc
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_t;

    localparam logic [3:0]       LAT_LAST = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_fill_cnt;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_ff_valid;
    logic [CNT_W-1:0] r_ff_idx;

    logic w_start_acc;
    logic w_busy;
    logic w_gold;
    logic w_exp;
    logic w_cmp;
    logic w_mis;

    assign w_start_acc = rc.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_busy      = (r_state == S_FILL) || (r_state == S_CHECK);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (rc.start) w_state_nxt = (LATENCY == 0) ? S_CHECK : S_FILL;
            end
            S_FILL: begin
                if (rc.stop)                       w_state_nxt = S_DONE;
                else if (r_fill_cnt == LAT_LAST)   w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (rc.stop) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
            r_mode     <= '0;
        end else if (w_start_acc) begin
            r_fill_cnt <= '0;
            r_mode     <= rc.func_sel;
        end else if (r_state == S_FILL) begin
            r_fill_cnt <= r_fill_cnt + 4'd1;
        end
    end

    always_comb begin
        case (r_mode)
            2'b00:   w_gold = rc.a & rc.b;
            2'b01:   w_gold = rc.a | rc.b;
            2'b10:   w_gold = rc.a ^ rc.b;
            default: w_gold = ~(rc.a & rc.b);
        endcase
    end

    // Golden delay line: element 0 holds the value for the stimulus sampled at the last edge.
    generate
        if (LATENCY == 0) begin : g_lat0
            assign w_exp = w_gold;
        end else begin : g_pipe
            logic r_gold_p [LATENCY];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) r_gold_p[i] <= 1'b0;
                end else if (w_busy) begin
                    r_gold_p[0] <= w_gold;
                    for (int i = 1; i < LATENCY; i++) r_gold_p[i] <= r_gold_p[i-1];
                end
            end
            assign w_exp = r_gold_p[LATENCY-1];
        end
    endgenerate

    // An X or Z on y fails the case-inequality test, so it is counted as a mismatch.
    assign w_cmp = (r_state == S_CHECK);
    assign w_mis = (rc.y !== w_exp);

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
        end else if (w_cmp) begin
            if (r_vec_cnt != CNT_MAX) r_vec_cnt <= r_vec_cnt + 1'b1;
            if (w_mis) begin
                if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_idx   <= r_vec_cnt;
                end
            end
        end
    end

    assign rc.busy             = w_busy;
    assign rc.done             = (r_state == S_DONE);
    assign rc.pass             = (r_state == S_DONE) && (r_err_cnt == '0) && (r_vec_cnt != '0);
    assign rc.vec_cnt          = r_vec_cnt;
    assign rc.err_cnt          = r_err_cnt;
    assign rc.first_fail_valid = r_ff_valid;
    assign rc.first_fail_idx   = r_ff_idx;

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker: three checker instances (LATENCY 1, 0 and 3), each watching a cell model.
// The cell models can be made to produce wrong outputs on purpose.
module tb_response_checker;

    logic       clk;
    logic       rst_n;
    logic [2:0] st;
    logic       stop;
    logic [1:0] func_sel;
    logic       a, b;
    logic [1:0] cell_fn;
    logic       inj, inv;
    logic       cell1;
    logic       c3_0, c3_1, c3_2;
    int         n_chk, n_fail;

    response_checker_if #(.CNT_W(8)) bus1 ();
    response_checker_if #(.CNT_W(8)) bus0 ();
    response_checker_if #(.CNT_W(8)) bus3 ();

    response_checker #(.LATENCY(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .rc(bus1));
    response_checker #(.LATENCY(0), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .rc(bus0));
    response_checker #(.LATENCY(3), .CNT_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .rc(bus3));

    function automatic logic gf(input logic [1:0] f, input logic x, input logic z);
        case (f)
            2'b00:   return x & z;
            2'b01:   return x | z;
            2'b10:   return x ^ z;
            default: return ~(x & z);
        endcase
    endfunction

    // Cell models: a one-stage registered cell with fault injection, a combinational OR, and a three-stage XOR.
    always @(posedge clk) begin
        cell1 <= gf(cell_fn, a, b) ^ inj ^ inv;
        c3_0  <= a ^ b;
        c3_1  <= c3_0;
        c3_2  <= c3_1;
    end

    assign bus1.start = st[1];
    assign bus0.start = st[0];
    assign bus3.start = st[2];
    assign bus1.stop = stop;  assign bus0.stop = stop;  assign bus3.stop = stop;
    assign bus1.func_sel = func_sel;  assign bus0.func_sel = func_sel;  assign bus3.func_sel = func_sel;
    assign bus1.a = a;  assign bus0.a = a;  assign bus3.a = a;
    assign bus1.b = b;  assign bus0.b = b;  assign bus3.b = b;
    assign bus1.y = cell1;
    assign bus0.y = a | b;
    assign bus3.y = c3_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pattern used for vector k: (0,0), (1,0), (1,1), (0,1), and then repeating.
    task automatic set_vec(input int k);
        logic [1:0] kk;
        kk = 2'(k);
        a  = kk[0] ^ kk[1];
        b  = kk[1];
    endtask

    task automatic start_run(input int which, input logic [1:0] fs, input logic with_stop);
        func_sel  = fs;
        cell_fn   = fs;
        st        = '0;
        st[which] = 1'b1;
        stop      = with_stop;
        tick();
        st   = '0;
        stop = 1'b0;
    endtask

    // Drives nvec vectors, then raises stop for one cycle; the compare in the stop cycle still counts.
    task automatic drive_run(input int nvec, input int inj_idx, input logic invert);
        inv = invert;
        for (int k = 0; k < nvec; k++) begin
            set_vec(k);
            inj = (k == inj_idx);
            tick();
        end
        a = 1'b0; b = 1'b0; inj = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        inv  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int v, input int e, input logic p, input logic fv, input int fi);
        chk({tag, "_done"}, bus1.done, 1'b1);
        chk({tag, "_busy"}, bus1.busy, 1'b0);
        chk({tag, "_vec"},  bus1.vec_cnt, v);
        chk({tag, "_err"},  bus1.err_cnt, e);
        chk({tag, "_pass"}, bus1.pass, p);
        chk({tag, "_ffv"},  bus1.first_fail_valid, fv);
        chk({tag, "_ffi"},  bus1.first_fail_idx, fi);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; st = '0; stop = 1'b0; func_sel = 2'b00; a = 1'b0; b = 1'b0;
        cell_fn = 2'b00; inj = 1'b0; inv = 1'b0;
        tick(); tick();
        chk("rst_busy", bus1.busy, 1'b0);
        chk("rst_done", bus1.done, 1'b0);
        chk("rst_pass", bus1.pass, 1'b0);
        chk("rst_vec",  bus1.vec_cnt, 0);
        chk("rst_err",  bus1.err_cnt, 0);
        chk("rst_ffv",  bus1.first_fail_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic pass run: AND, four vectors.
        start_run(1, 2'b00, 1'b0);
        chk("basic_busy_rise", bus1.busy, 1'b1);
        chk("basic_pass_low_while_busy", bus1.pass, 1'b0);
        drive_run(4, -1, 1'b0);
        chk_res("basic", 4, 0, 1'b1, 1'b0, 0);

        // Single injected error on compare index 2.
        start_run(1, 2'b00, 1'b0);
        drive_run(4, 2, 1'b0);
        chk_res("inj", 4, 1, 1'b0, 1'b1, 2);

        // Saturation: XOR with an always-inverted cell for 300 compares.
        start_run(1, 2'b10, 1'b0);
        drive_run(300, -1, 1'b1);
        chk_res("sat", 255, 255, 1'b0, 1'b1, 0);

        // Restart from DONE with start and stop together; NAND must be the latched mode.
        start_run(1, 2'b11, 1'b1);
        chk("rs_busy", bus1.busy, 1'b1);
        chk("rs_done", bus1.done, 1'b0);
        chk("rs_vec",  bus1.vec_cnt, 0);
        chk("rs_err",  bus1.err_cnt, 0);
        chk("rs_ffv",  bus1.first_fail_valid, 1'b0);
        drive_run(4, -1, 1'b0);
        chk_res("rs_nand", 4, 0, 1'b1, 1'b0, 0);

        // Mid-run reset after two errors.
        start_run(1, 2'b00, 1'b0);
        inv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_vec(k);
            tick();
        end
        chk("mr_err_before", bus1.err_cnt, 2);
        chk("mr_busy_before", bus1.busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        inv   = 1'b0;
        chk("mr_busy", bus1.busy, 1'b0);
        chk("mr_done", bus1.done, 1'b0);
        chk("mr_vec",  bus1.vec_cnt, 0);
        chk("mr_err",  bus1.err_cnt, 0);
        chk("mr_ffv",  bus1.first_fail_valid, 1'b0);
        chk("mr_ffi",  bus1.first_fail_idx, 0);
        start_run(1, 2'b00, 1'b0);
        drive_run(4, -1, 1'b0);
        chk_res("mr_rerun", 4, 0, 1'b1, 1'b0, 0);

        // Zero latency, OR with a combinational y: the first compare happens right after start.
        start_run(0, 2'b01, 1'b0);
        chk("l0_busy", bus0.busy, 1'b1);
        set_vec(0); tick();
        chk("l0_vec_after1", bus0.vec_cnt, 1);
        set_vec(1); tick();
        set_vec(2); stop = 1'b1; tick();
        stop = 1'b0;
        chk("l0_done", bus0.done, 1'b1);
        chk("l0_vec",  bus0.vec_cnt, 3);
        chk("l0_err",  bus0.err_cnt, 0);
        chk("l0_pass", bus0.pass, 1'b1);

        // Latency 3: stop in the second FILL cycle.
        start_run(2, 2'b10, 1'b0);
        chk("l3_fill_busy", bus3.busy, 1'b1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("l3es_done", bus3.done, 1'b1);
        chk("l3es_busy", bus3.busy, 1'b0);
        chk("l3es_vec",  bus3.vec_cnt, 0);
        chk("l3es_pass", bus3.pass, 1'b0);

        // Latency 3 full run: 6 vectors, 3 FILL cycles, so 4 compares.
        start_run(2, 2'b10, 1'b0);
        for (int k = 0; k < 6; k++) begin
            set_vec(k);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("l3_vec",  bus3.vec_cnt, 4);
        chk("l3_err",  bus3.err_cnt, 0);
        chk("l3_pass", bus3.pass, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
